// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory load/store unit: FSM states,
// Funct3 access-size codes and request legality helpers.
package dmem_access_unit_pkg;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_WAIT = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants, so only b/h/w are legal for them.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !is_store;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return (lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load result formatting: picks the byte/halfword lane out of the memory
// word and sign- or zero-extends it to 32 bits.
module load_extend
  import dmem_access_unit_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension according to the access type.
  always_comb begin
    byte_s = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_s = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3)
      F3_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
      F3_H:    rdata_ext = {{16{half_s[15]}}, half_s};
      F3_W:    rdata_ext = mem_rdata;
      F3_BU:   rdata_ext = {24'd0, byte_s};
      F3_HU:   rdata_ext = {16'd0, half_s};
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// RV32I load/store unit: turns decode requests into word-aligned memory
// transactions with byte strobes and stalls the core until acknowledge.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W+1:0] addr,
  input  logic [BITS-1:0]   wdata,
  output logic [BITS-1:0]   rdata,
  output logic              stall,
  output logic              access_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BITS-1:0]   mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [BITS-1:0]   mem_rdata,
  input  logic              mem_ready
);

  ma_state_e         state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BITS-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic [BITS-1:0]   rdata_q, rdata_d;
  logic [1:0]        lane_q, lane_d;
  logic [2:0]        f3_q, f3_d;

  logic              err_s;
  logic              valid_s;
  logic              stall_s;
  logic [3:0]        wstrb_s;
  logic [BITS-1:0]   wdata_s;
  logic [BITS-1:0]   ext_s;

  // Request legality: conflicting strobes, bad size code or misalignment.
  always_comb begin
    err_s = 1'b0;
    if (MemRead && MemWrite) begin
      err_s = 1'b1;
    end else if (MemRead) begin
      err_s = !f3_legal(1'b0, Funct3) || f3_misaligned(Funct3, addr[1:0]);
    end else if (MemWrite) begin
      err_s = !f3_legal(1'b1, Funct3) || f3_misaligned(Funct3, addr[1:0]);
    end else begin
      err_s = 1'b0;
    end
  end

  assign valid_s = (MemRead ^ MemWrite) && !err_s;

  // Store data is replicated across lanes so memory only needs the strobes.
  always_comb begin
    wstrb_s = 4'b0000;
    wdata_s = '0;
    if (MemWrite) begin
      case (Funct3)
        F3_B: begin
          wstrb_s = 4'b0001 << addr[1:0];
          wdata_s = {4{wdata[7:0]}};
        end
        F3_H: begin
          wstrb_s = addr[1] ? 4'b1100 : 4'b0011;
          wdata_s = {2{wdata[15:0]}};
        end
        F3_W: begin
          wstrb_s = 4'b1111;
          wdata_s = wdata;
        end
        default: begin
          wstrb_s = 4'b0000;
          wdata_s = '0;
        end
      endcase
    end else begin
      wstrb_s = 4'b0000;
      wdata_s = '0;
    end
  end

  load_extend u_load_extend (
    .mem_rdata (mem_rdata),
    .addr_lo   (lane_q),
    .funct3    (f3_q),
    .rdata_ext (ext_s)
  );

  // Next-state and transaction register updates.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    rdata_d     = rdata_q;
    lane_d      = lane_q;
    f3_d        = f3_q;
    stall_s     = 1'b0;
    case (state_q)
      MA_IDLE: begin
        if (valid_s) begin
          stall_s     = 1'b1;
          state_d     = MA_WAIT;
          mem_read_d  = MemRead;
          mem_write_d = MemWrite;
          mem_addr_d  = addr[ADDR_W+1:2];
          mem_wdata_d = wdata_s;
          mem_wstrb_d = wstrb_s;
          lane_d      = addr[1:0];
          f3_d        = Funct3;
        end else begin
          state_d = MA_IDLE;
        end
      end
      MA_WAIT: begin
        stall_s = 1'b1;
        if (mem_ready) begin
          state_d     = MA_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          rdata_d     = mem_read_q ? ext_s : rdata_q;
        end else begin
          state_d = MA_WAIT;
        end
      end
      MA_DONE: begin
        // The request is still on the inputs here; it must not be re-issued.
        state_d = MA_IDLE;
      end
      default: begin
        state_d = MA_IDLE;
      end
    endcase
  end

  // State and transaction registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MA_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'b0000;
      rdata_q     <= '0;
      lane_q      <= 2'b00;
      f3_q        <= 3'b000;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rdata_q     <= rdata_d;
      lane_q      <= lane_d;
      f3_q        <= f3_d;
    end
  end

  assign stall      = rst_n && stall_s;
  assign access_err = err_s;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign rdata      = ((state_q == MA_IDLE) && err_s) ? '0 : rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: a byte-addressed reference
// memory predicts load results, strobes and stored bytes.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n, MemRead, MemWrite, mem_ready;
  logic [2:0]  Funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] rdata, mem_wdata;
  logic        stall, access_err, mem_read, mem_write;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstrb;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  ref_b [0:1023];
  logic [7:0]  mem_b [0:1023];
  logic [31:0] last_rdata;
  logic [2:0]  f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  always #5 clk = ~clk;

  dmem_access_unit #(.BITS(32), .ADDR_W(30)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .access_err(access_err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic model_err(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = size_of(f3);
    if (rd && wr) return 1'b1;
    if (!rd && !wr) return 1'b0;
    if (n == 0 || (wr && f3[2])) return 1'b1;
    return (int'(a[1:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v, sb;
    int n;
    n = size_of(f3);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[10'(a + 32'(i))]) << (8 * i));
    if (!f3[2] && n < 4) begin
      sb = 32'd1 << (8 * n - 1);
      v  = (v ^ sb) - sb;
    end
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [9:0] base);
    return {mem_b[base + 10'd3], mem_b[base + 10'd2], mem_b[base + 10'd1], mem_b[base]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [9:0] base);
    return {ref_b[base + 10'd3], ref_b[base + 10'd2], ref_b[base + 10'd1], ref_b[base]};
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ref_b[10'(a + 32'(i))] = w[8*i +: 8];
      mem_b[10'(a + 32'(i))] = w[8*i +: 8];
    end
  endtask

  // One legal access from the IDLE cycle through DONE; caller is at posedge+1.
  task automatic do_access(input logic rd, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int lat, output int stall_cnt);
    int n;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd, exp_rd;
    logic [9:0]  base;
    n = size_of(f3);
    exp_strb = 4'b0000;
    if (!rd) for (int i = 0; i < n; i++) exp_strb[int'(a[1:0]) + i] = 1'b1;
    for (int k = 0; k < 4; k++) exp_wd[8*k +: 8] = wd[8*(k % n) +: 8];
    exp_rd = rd ? model_load(f3, a) : last_rdata;
    if (!rd) for (int i = 0; i < n; i++) ref_b[10'(a + 32'(i))] = wd[8*i +: 8];
    MemRead = rd; MemWrite = !rd; Funct3 = f3; addr = a; wdata = wd; mem_ready = 1'b0;
    stall_cnt = 0;
    @(negedge clk);
    checks++;
    if ({stall, access_err, mem_read, mem_write} !== 4'b1000) begin
      failures++;
      $display("FAIL issue a=%h got=%b exp=1000", a, {stall, access_err, mem_read, mem_write});
    end
    if (stall) stall_cnt++;
    @(posedge clk); #1;
    for (int c = 0; c <= lat; c++) begin
      mem_ready = (c == lat);
      mem_rdata = (c == lat && rd) ? mem_word({a[9:2], 2'b00}) : $urandom;
      @(negedge clk);
      checks++;
      if ({stall, mem_read, mem_write, mem_addr, mem_wstrb} !== {1'b1, rd, !rd, a[31:2], exp_strb}) begin
        failures++;
        $display("FAIL wait a=%h got=%h exp=%h", a, {stall, mem_read, mem_write, mem_addr, mem_wstrb},
                 {1'b1, rd, !rd, a[31:2], exp_strb});
      end
      if (!rd) begin
        checks++;
        if (mem_wdata !== exp_wd) begin
          failures++;
          $display("FAIL wdata a=%h got=%h exp=%h", a, mem_wdata, exp_wd);
        end
      end
      if (stall) stall_cnt++;
      if (mem_ready && mem_write) begin
        base = {mem_addr[7:0], 2'b00};
        for (int k = 0; k < 4; k++) if (mem_wstrb[k]) mem_b[base + 10'(k)] = mem_wdata[8*k +: 8];
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    @(negedge clk);
    checks++;
    if ({stall, mem_read, mem_write} !== 3'b000 || rdata !== exp_rd) begin
      failures++;
      $display("FAIL done a=%h got=%b/%h exp=000/%h", a, {stall, mem_read, mem_write}, rdata, exp_rd);
    end
    last_rdata = exp_rd;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    if (!rd) begin
      checks++;
      if (mem_word({a[9:2], 2'b00}) !== ref_word({a[9:2], 2'b00})) begin
        failures++;
        $display("FAIL memword a=%h got=%h exp=%h", a, mem_word({a[9:2], 2'b00}), ref_word({a[9:2], 2'b00}));
      end
    end
  endtask

  task automatic idle_check(input string tag);
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, mem_read, mem_write, access_err} !== 4'b0000 || rdata !== last_rdata) begin
      failures++;
      $display("FAIL %s got=%b/%h exp=0000/%h", tag, {stall, mem_read, mem_write, access_err}, rdata, last_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; addr = 32'h10;
    wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0; last_rdata = 32'h0;
    #1 rst_n = 1'b0;
    #11;
    checks++;
    if ({stall, mem_read, mem_write, mem_wstrb} !== 7'b0 || mem_addr !== 30'd0 ||
        mem_wdata !== 32'd0 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset got=%b/%h/%h/%h exp=0", {stall, mem_read, mem_write, mem_wstrb}, mem_addr, mem_wdata, rdata);
    end
    MemRead = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle_check("idle_after_reset");
    idle_check("idle_stays");
  endtask

  task automatic test_lw();
    int sc;
    preload(32'h100, 32'hDEADBEEF);
    do_access(1'b1, 3'b010, 32'h100, 32'h0, 1, sc);
    checks++;
    if (sc != 3) begin failures++; $display("FAIL lw_stall got=%0d exp=3", sc); end
    MemRead = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata !== 32'hDEADBEEF || mem_read !== 1'b0) begin
      failures++;
      $display("FAIL lw_hold got=%h/%b exp=deadbeef/0", rdata, mem_read);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int sc;
    preload(32'h100, 32'h80FF0011);
    do_access(1'b1, 3'b000, 32'h103, 32'h0, 0, sc);
    checks++;
    if (sc != 2) begin failures++; $display("FAIL lb_stall got=%0d exp=2", sc); end
    do_access(1'b1, 3'b100, 32'h103, 32'h0, 2, sc);
    idle_check("lbu_hold");
    checks++;
    if (rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_val got=%h exp=00000080", rdata); end
  endtask

  task automatic test_store_half();
    int sc;
    do_access(1'b0, 3'b001, 32'h202, 32'h1234ABCD, 3, sc);
    checks++;
    if (sc != 5) begin failures++; $display("FAIL sh_stall got=%0d exp=5", sc); end
    idle_check("sh_idle");
  endtask

  task automatic test_errors();
    logic rd, wr; logic [2:0] f3; logic [31:0] a; logic exp_err;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       begin rd = 1'b1; wr = 1'b0; f3 = 3'b010; a = 32'h101; end
        1:       begin rd = 1'b0; wr = 1'b1; f3 = 3'b001; a = 32'h203; end
        2:       begin rd = 1'b1; wr = 1'b1; f3 = 3'b010; a = 32'h100; end
        3:       begin rd = 1'b0; wr = 1'b1; f3 = 3'b100; a = 32'h004; end
        4:       begin rd = 1'b1; wr = 1'b0; f3 = 3'b011; a = 32'h008; end
        default: begin rd = 1'b1; wr = 1'b0; f3 = 3'b101; a = 32'h105; end
      endcase
      exp_err = model_err(rd, wr, f3, a);
      MemRead = rd; MemWrite = wr; Funct3 = f3; addr = a; wdata = $urandom;
      @(negedge clk);
      checks++;
      if ({access_err, stall, mem_read, mem_write} !== {exp_err, 3'b000} || rdata !== 32'd0) begin
        failures++;
        $display("FAIL err%0d got=%b/%h exp=%b000/0", i, {access_err, stall, mem_read, mem_write}, rdata, exp_err);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({stall, mem_read, mem_write} !== 3'b000) begin
        failures++;
        $display("FAIL err%0d_notxn got=%b exp=000", i, {stall, mem_read, mem_write});
      end
      @(posedge clk); #1;
    end
    idle_check("err_recover");
  endtask

  task automatic test_random();
    logic rd, wr, exp_err; logic [2:0] f3; logic [31:0] a, wd; int n, sc, lat;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        rd = 1'($urandom); wr = 1'($urandom); f3 = 3'($urandom);
      end else begin
        rd = 1'($urandom); wr = !rd;
        f3 = rd ? f3_tab[$urandom_range(0, 4)] : f3_tab[$urandom_range(0, 2)];
      end
      n = size_of(f3);
      a = 32'($urandom_range(0, 1023));
      if (n > 0 && $urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
      wd = $urandom;
      exp_err = model_err(rd, wr, f3, a);
      if ((rd ^ wr) && !exp_err) begin
        lat = $urandom_range(0, 3);
        do_access(rd, f3, a, wd, lat, sc);
        checks++;
        if (sc != 2 + lat) begin failures++; $display("FAIL rnd_stall got=%0d exp=%0d", sc, 2 + lat); end
        if ($urandom_range(0, 1) == 1) idle_check("rnd_idle");
      end else begin
        MemRead = rd; MemWrite = wr; Funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        checks++;
        if ({access_err, stall, mem_read, mem_write} !== {exp_err, 3'b000} ||
            rdata !== (exp_err ? 32'd0 : last_rdata)) begin
          failures++;
          $display("FAIL rnd_noreq got=%b/%h exp=%b000", {access_err, stall, mem_read, mem_write}, rdata, exp_err);
        end
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
      end
    end
    idle_check("rnd_end");
  endtask

  task automatic test_reset_in_wait();
    int sc;
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; addr = 32'h100; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({stall, mem_read} !== 2'b11) begin failures++; $display("FAIL rw_pre got=%b exp=11", {stall, mem_read}); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, mem_read, mem_write, mem_wstrb} !== 7'b0 || mem_addr !== 30'd0 || rdata !== 32'd0) begin
      failures++;
      $display("FAIL rw_reset got=%b/%h/%h exp=0", {stall, mem_read, mem_write, mem_wstrb}, mem_addr, rdata);
    end
    last_rdata = 32'd0;
    MemRead = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 3'b010, 32'h300, $urandom, 1, sc);
    checks++;
    if (sc != 3) begin failures++; $display("FAIL rw_sw_stall got=%0d exp=3", sc); end
    idle_check("rw_idle");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_b[i] = 8'($urandom);
      mem_b[i] = ref_b[i];
    end
    test_reset();
    test_lw();
    test_back_to_back();
    test_store_half();
    test_errors();
    test_random();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
